tpg_pattern_gen: RTL and testbench
==================================

# tpg_pattern_gen

Parametrised test-pattern generator inserted in the RGB video path between the input timing source and the output formatter. It either passes the incoming pixel stream through or replaces active pixels with one of several generated patterns. Sync signals are kept cycle-aligned with the data. The selected mode only changes at frame boundaries, so a frame never tears.

## Interface
Parameters:
- H_ACTIVE, 1920, active pixels per line
- V_ACTIVE, 1080, active lines per frame
- DW, 8, bits per colour component
- CHECK_LOG2, 6, checker square edge = 2^CHECK_LOG2 pixels
- FLAT_RGB, {3{8'h77}}, flat-colour value as {R,G,B}, 3*DW bits

Ports:
- i_pclk  in  1  pixel clock; the only clock
- i_rst  in  1  synchronous, active-high reset
- i_sync_h  in  1  line-valid, high during active pixels
- i_sync_v  in  1  frame-valid, high during active lines
- i_r / i_g / i_b  in  DW each  input pixel
- i_mode  in  3  requested pattern mode; may change at any time
- o_sync_h / o_sync_v  out  1 each  delayed syncs
- o_r / o_g / o_b  out  DW each  output pixel
- o_mode  out  3  mode currently in effect

## Operation
- Mode is latched from i_mode in the cycle where i_sync_v rises (i_sync_v=1, previous value 0). It holds for the whole frame.
- Mode encodings:
  - 0: passthrough.
  - 1: flat FLAT_RGB.
  - 2: 8-bar colour bar (white, yellow, cyan, green, magenta, red, blue, black). Full scale is 2^DW-1.
  - 3: horizontal ramp. All components = hcount[DW-1:0].
  - 4: RGB thirds. The active component is hcount[DW-1:0], the others are 0. R for vcount < V_ACTIVE/3, G for vcount < 2*V_ACTIVE/3, B otherwise.
  - 5: checkerboard. White when hcount[CHECK_LOG2]^vcount[CHECK_LOG2] = 1, else black.
  - 6–7: treated as passthrough. o_mode still reports the latched value.
- Counters are CW = $clog2(max(H_ACTIVE,V_ACTIVE)+1) bits wide.
- hcount:
  - Cleared when i_sync_h=0.
  - Increments each cycle i_sync_h=1.
  - Saturates at all-ones.
- vcount:
  - Cleared when i_sync_v=0.
  - Increments on each falling edge of i_sync_h while i_sync_v=1.
  - Saturates at all-ones.
- Bar index = hcount / (H_ACTIVE/8), with integer division done at elaboration. Indices above 7 clamp to 7 (black).
- Lines with vcount ≥ V_ACTIVE use B in mode 4.
- While i_sync_h=0 or i_sync_v=0, generated modes output 0. Passthrough forwards input unchanged, including blanking.

## Timing
- Latency is fixed at 2 cycles for data and syncs alike.
  - Stage 1 registers counters, the latched mode, and the delayed input pixel/syncs.
  - Stage 2 registers the mode mux output.
- o_mode updates 1 cycle after the latching edge. It is not aligned to the data pipe.
- Reset values: o_r/o_g/o_b = 0, o_sync_h/o_sync_v = 0, o_mode = 0, counters = 0. The rise detector's previous-value register is 0.
- Reset asserted mid-frame: the next cycle's outputs are 0.
- Reset released mid-frame:
  - i_sync_v already high counts as a rise. The mode latches on the first post-reset cycle.
  - vcount and hcount restart from 0, so the partial frame is mispositioned but well-formed.
- i_mode changing in the same cycle as the rising edge: the new value is latched.
- Frames with no i_sync_v low period keep the old mode.

## Configuration
- TPG_BORDER_EN defined:
  - In modes 1–5, pixels with hcount==0, hcount==H_ACTIVE-1, vcount==0 or vcount==V_ACTIVE-1 are forced to full-scale white.
  - Passthrough and blanking are unaffected.
  - Adds no latency.
- TPG_BORDER_EN undefined: no border logic is present; behaviour is exactly as above.

## Structure
- Package tpg_pkg holds:
  - tpg_mode_e, a 3-bit enum (TPG_PASS, TPG_FLAT, TPG_BAR, TPG_RAMP, TPG_THIRDS, TPG_CHECK).
  - The 8-entry bar colour table as 1-bit {R,G,B} flags.
  - A function expanding a flag to DW bits.
- Sub-module tpg_timing_cnt provides hcount, vcount, frame-start pulse and line-end pulse. It is parametrised by CW.
- The top level holds the mode latch, pattern mux and output pipe.

## Test plan
Bench uses defaults (1920×1080, DW=8).
- Reset, mode 0, input pixel 0x12/0x34/0x56 with syncs high → the same values and syncs appear exactly 2 cycles later.
- i_mode=2 set before a frame → pixel hcount=0 gives FF/FF/FF, hcount=240 gives FF/FF/00, hcount=1919 gives 00/00/00.
- i_mode=4 → line 0, hcount=300 gives 2C/00/00; line 360 gives 00/2C/00; line 720 gives 00/00/2C.
- Switch i_mode 1→5 mid-frame → rest of frame stays 77/77/77. Checker appears from the next frame: pixel (64,0) is FF/FF/FF, pixel (64,64) is 00/00/00.
- i_rst pulsed mid-line in mode 3 → outputs 0 the next cycle. o_mode is 0 until the next frame start, then 3.
- With TPG_BORDER_EN, mode 1 → line 0 and column 1919 are FF/FF/FF; pixel (5,5) is 77/77/77.

Source files
------------

// File: rtl/tpg_pkg.sv
// Shared definitions for the test-pattern generator: mode encoding,
// colour-bar table and flag expansion helper.
package tpg_pkg;

  localparam int unsigned TPG_MODE_W = 3;
  localparam int unsigned TPG_BAR_N  = 8;
  localparam int unsigned TPG_MAX_DW = 32;

  typedef enum logic [TPG_MODE_W-1:0] {
    TPG_PASS   = 3'd0,
    TPG_FLAT   = 3'd1,
    TPG_BAR    = 3'd2,
    TPG_RAMP   = 3'd3,
    TPG_THIRDS = 3'd4,
    TPG_CHECK  = 3'd5
  } tpg_mode_e;

  // One-bit-per-component colour, expanded to full scale at use.
  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } tpg_flag_rgb_t;

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam tpg_flag_rgb_t [TPG_BAR_N-1:0] TPG_BAR_TABLE = {
    3'b000,  // 7 black
    3'b001,  // 6 blue
    3'b100,  // 5 red
    3'b101,  // 4 magenta
    3'b010,  // 3 green
    3'b011,  // 2 cyan
    3'b110,  // 1 yellow
    3'b111   // 0 white
  };

  // Replicate a colour flag to the widest supported component; callers cast down to DW.
  function automatic logic [TPG_MAX_DW-1:0] tpg_flag_expand(input logic flag);
    return {TPG_MAX_DW{flag}};
  endfunction

  // Modes 1..5 replace active pixels; 0, 6 and 7 forward the input.
  function automatic logic tpg_is_generated(input logic [TPG_MODE_W-1:0] mode);
    return (mode >= 3'(TPG_FLAT)) && (mode <= 3'(TPG_CHECK));
  endfunction

endpackage

// File: rtl/tpg_timing_cnt.sv
// Pixel/line position counters aligned to the first pipeline stage, plus the
// frame-start and line-end pulses derived from the incoming syncs.
module tpg_timing_cnt
  import tpg_pkg::*;
#(
  parameter int unsigned CW = 11
) (
  input  logic          i_pclk,
  input  logic          i_rst,
  input  logic          sync_h,
  input  logic          sync_v,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          sync_h_d,
  output logic          sync_v_d,
  output logic          frame_start_c,
  output logic          line_end_c
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  // Edge pulses use the previous-cycle syncs, which reset to 0 so a sync_v already high counts as a rise.
  assign frame_start_c = sync_v & ~sync_v_d;
  assign line_end_c    = sync_h_d & ~sync_h;

  // Counters describe the pixel now entering stage 1: the first active pixel of a line is 0.
  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      sync_h_d <= 1'b0;
      sync_v_d <= 1'b0;
      hcount   <= '0;
      vcount   <= '0;
    end else begin
      sync_h_d <= sync_h;
      sync_v_d <= sync_v;

      if (!sync_h || !sync_h_d) begin
        hcount <= '0;
      end else if (hcount != CNT_MAX) begin
        hcount <= hcount + CW'(1);
      end

      if (!sync_v) begin
        vcount <= '0;
      end else if (line_end_c && (vcount != CNT_MAX)) begin
        vcount <= vcount + CW'(1);
      end
    end
  end

endmodule

// File: rtl/tpg_pattern_gen.sv
// RGB test-pattern generator with a fixed two-cycle pipe.
// Optional build macro: TPG_BORDER_EN forces a one-pixel white frame border
// in the generated modes.
module tpg_pattern_gen
  import tpg_pkg::*;
#(
  parameter int unsigned      H_ACTIVE   = 1920,
  parameter int unsigned      V_ACTIVE   = 1080,
  parameter int unsigned      DW         = 8,
  parameter int unsigned      CHECK_LOG2 = 6,
  parameter logic [3*DW-1:0]  FLAT_RGB   = {3{8'h77}}
) (
  input  logic                  i_pclk,
  input  logic                  i_rst,
  input  logic                  i_sync_h,
  input  logic                  i_sync_v,
  input  logic [DW-1:0]         i_r,
  input  logic [DW-1:0]         i_g,
  input  logic [DW-1:0]         i_b,
  input  logic [TPG_MODE_W-1:0] i_mode,
  output logic                  o_sync_h,
  output logic                  o_sync_v,
  output logic [DW-1:0]         o_r,
  output logic [DW-1:0]         o_g,
  output logic [DW-1:0]         o_b,
  output logic [TPG_MODE_W-1:0] o_mode
);

  localparam int unsigned MAX_DIM  = (H_ACTIVE > V_ACTIVE) ? H_ACTIVE : V_ACTIVE;
  localparam int unsigned CW       = $clog2(MAX_DIM + 1);
  localparam int unsigned BAR_W    = H_ACTIVE / TPG_BAR_N;
  localparam int unsigned V_THIRD1 = V_ACTIVE / 3;
  localparam int unsigned V_THIRD2 = (2 * V_ACTIVE) / 3;
  localparam logic [DW-1:0] FULL   = {DW{1'b1}};

  logic [CW-1:0]         hcount;
  logic [CW-1:0]         vcount;
  logic                  sync_h_d;
  logic                  sync_v_d;
  logic                  frame_start_c;
  logic                  line_end_c;
  logic                  unused_line_end;
  logic [DW-1:0]         r_d, g_d, b_d;
  logic [TPG_MODE_W-1:0] mode_q;
  logic [2:0]            bar_idx;
  tpg_flag_rgb_t         bar_flags;
  logic [DW-1:0]         ramp;
  logic                  chk;
  logic [DW-1:0]         pix_r, pix_g, pix_b;

  tpg_timing_cnt #(
    .CW (CW)
  ) u_timing_cnt (
    .i_pclk        (i_pclk),
    .i_rst         (i_rst),
    .sync_h        (i_sync_h),
    .sync_v        (i_sync_v),
    .hcount        (hcount),
    .vcount        (vcount),
    .sync_h_d      (sync_h_d),
    .sync_v_d      (sync_v_d),
    .frame_start_c (frame_start_c),
    .line_end_c    (line_end_c)
  );

  // Line-end pulse is only needed inside the counter block.
  assign unused_line_end = line_end_c;

`ifdef TPG_BORDER_EN
  logic border_hit;

  // Outermost active row/column of the nominal frame.
  assign border_hit = (hcount == CW'(0)) || (hcount == CW'(H_ACTIVE - 1)) ||
                      (vcount == CW'(0)) || (vcount == CW'(V_ACTIVE - 1));
`endif

  // Stage 1: mode latch at frame start and delayed input pixel.
  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      mode_q <= '0;
      r_d    <= '0;
      g_d    <= '0;
      b_d    <= '0;
    end else begin
      if (frame_start_c) begin
        mode_q <= i_mode;
      end
      r_d <= i_r;
      g_d <= i_g;
      b_d <= i_b;
    end
  end

  assign o_mode = mode_q;

  // Pattern selection for the pixel held in stage 1.
  always_comb begin
    pix_r   = '0;
    pix_g   = '0;
    pix_b   = '0;
    bar_idx = '0;
    ramp    = DW'(hcount);
    chk     = hcount[CHECK_LOG2] ^ vcount[CHECK_LOG2];

    // Bar index by threshold compare; anything past bar 7 stays black.
    for (int unsigned k = 1; k < TPG_BAR_N; k++) begin
      if (hcount >= CW'(k * BAR_W)) begin
        bar_idx = 3'(k);
      end
    end
    bar_flags = TPG_BAR_TABLE[bar_idx];

    if (!tpg_is_generated(mode_q)) begin
      pix_r = r_d;
      pix_g = g_d;
      pix_b = b_d;
    end else if (sync_h_d && sync_v_d) begin
      case (mode_q)
        TPG_FLAT: begin
          {pix_r, pix_g, pix_b} = FLAT_RGB;
        end
        TPG_BAR: begin
          pix_r = DW'(tpg_flag_expand(bar_flags.r));
          pix_g = DW'(tpg_flag_expand(bar_flags.g));
          pix_b = DW'(tpg_flag_expand(bar_flags.b));
        end
        TPG_RAMP: begin
          pix_r = ramp;
          pix_g = ramp;
          pix_b = ramp;
        end
        TPG_THIRDS: begin
          if (vcount < CW'(V_THIRD1)) begin
            pix_r = ramp;
          end else if (vcount < CW'(V_THIRD2)) begin
            pix_g = ramp;
          end else begin
            pix_b = ramp;
          end
        end
        TPG_CHECK: begin
          pix_r = {DW{chk}};
          pix_g = {DW{chk}};
          pix_b = {DW{chk}};
        end
        default: begin
        end
      endcase
`ifdef TPG_BORDER_EN
      if (border_hit) begin
        pix_r = FULL;
        pix_g = FULL;
        pix_b = FULL;
      end
`endif
    end
  end

  // Stage 2: registered pixel and syncs.
  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      o_sync_h <= 1'b0;
      o_sync_v <= 1'b0;
      o_r      <= '0;
      o_g      <= '0;
      o_b      <= '0;
    end else begin
      o_sync_h <= sync_h_d;
      o_sync_v <= sync_v_d;
      o_r      <= pix_r;
      o_g      <= pix_g;
      o_b      <= pix_b;
    end
  end

  // Saturated white is only referenced by the border option.
  logic unused_full;
  assign unused_full = &FULL;

endmodule

// File: tb/tb_tpg_pattern_gen.sv
// Self-checking bench for tpg_pattern_gen at default parameters.
module tb_tpg_pattern_gen;

  localparam int H_ACT = 1920;
  localparam int V_ACT = 1080;
  localparam int CMAX  = 2047;
`ifdef TPG_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  localparam logic [23:0] BAR_COLOURS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  logic       i_pclk = 1'b0;
  logic       i_rst;
  logic       i_sync_h, i_sync_v;
  logic [7:0] i_r, i_g, i_b;
  logic [2:0] i_mode;
  logic       o_sync_h, o_sync_v;
  logic [7:0] o_r, o_g, o_b;
  logic [2:0] o_mode;

  always #5 i_pclk = ~i_pclk;

  tpg_pattern_gen dut (
    .i_pclk   (i_pclk),
    .i_rst    (i_rst),
    .i_sync_h (i_sync_h),
    .i_sync_v (i_sync_v),
    .i_r      (i_r),
    .i_g      (i_g),
    .i_b      (i_b),
    .i_mode   (i_mode),
    .o_sync_h (o_sync_h),
    .o_sync_v (o_sync_v),
    .o_r      (o_r),
    .o_g      (o_g),
    .o_b      (o_b),
    .o_mode   (o_mode)
  );

  typedef struct {
    bit          sh;
    bit          sv;
    bit          act;
    logic [23:0] rgb;
    int          tag;
    int          h;
    int          v;
  } rec_t;

  typedef struct {
    int          tag;
    int          h;
    int          v;
    logic [23:0] rgb;
    bit          hit;
  } probe_t;

  int     n_checks = 0;
  int     n_errors = 0;
  bit     chk_en   = 1'b0;
  bit     mode_flip = 1'b0;
  int     cur_tag  = 0;

  // Reference model state
  bit     m_prev_h, m_prev_v;
  int     m_run, m_lines, m_mode, m_omode;
  rec_t   pipe0, pipe1;

  probe_t probes [24];
  int     n_probes = 0;

  // Expected pixel from the pattern rules, using plain arithmetic.
  function automatic logic [23:0] model_pixel(input int mode, input int h, input int v,
                                              input bit act, input logic [23:0] pin);
    logic [23:0] c;
    logic [7:0]  lvl;
    int          bar;
    if (mode == 0 || mode > 5) return pin;
    if (!act) return 24'h0;
    lvl = 8'(h % 256);
    c   = 24'h0;
    case (mode)
      1: c = 24'h777777;
      2: begin
        bar = h / (H_ACT / 8);
        if (bar > 7) bar = 7;
        c = BAR_COLOURS[bar];
      end
      3: c = {lvl, lvl, lvl};
      4: begin
        if (v < V_ACT / 3)          c = {lvl, 16'h0};
        else if (v < 2 * V_ACT / 3) c = {8'h0, lvl, 8'h0};
        else                        c = {16'h0, lvl};
      end
      default: c = (((h / 64) % 2) != ((v / 64) % 2)) ? 24'hFFFFFF : 24'h0;
    endcase
    if (BORDER && (h == 0 || h == H_ACT - 1 || v == 0 || v == V_ACT - 1)) c = 24'hFFFFFF;
    return c;
  endfunction

  // One model step per clock: positions, mode latch, and a two-deep output delay.
  task automatic model_step();
    rec_t nr;
    int   h, v;
    if (i_rst) begin
      m_prev_h = 1'b0; m_prev_v = 1'b0;
      m_run = 0; m_lines = 0; m_mode = 0; m_omode = 0;
      pipe0 = '{default: 0};
      pipe1 = '{default: 0};
    end else begin
      h = (m_run > CMAX) ? CMAX : m_run;
      v = (m_lines > CMAX) ? CMAX : m_lines;
      if (i_sync_v && !m_prev_v) m_mode = int'(i_mode);
      nr.sh  = i_sync_h;
      nr.sv  = i_sync_v;
      nr.act = i_sync_h && i_sync_v;
      nr.h   = h;
      nr.v   = v;
      nr.tag = cur_tag;
      nr.rgb = model_pixel(m_mode, h, v, nr.act, {i_r, i_g, i_b});
      pipe1 = pipe0;
      pipe0 = nr;
      m_run = i_sync_h ? m_run + 1 : 0;
      if (!i_sync_v)                   m_lines = 0;
      else if (m_prev_h && !i_sync_h)  m_lines = m_lines + 1;
      m_prev_h = i_sync_h;
      m_prev_v = i_sync_v;
      m_omode  = m_mode;
    end
  endtask

  task automatic compare_step();
    n_checks++;
    if ({o_sync_h, o_sync_v, o_r, o_g, o_b} !== {pipe1.sh, pipe1.sv, pipe1.rgb}) begin
      n_errors++;
      $display("FAIL pixel t=%0t got sh=%0b sv=%0b rgb=%06h want sh=%0b sv=%0b rgb=%06h (tag %0d h %0d v %0d)",
               $time, o_sync_h, o_sync_v, {o_r, o_g, o_b}, pipe1.sh, pipe1.sv, pipe1.rgb,
               pipe1.tag, pipe1.h, pipe1.v);
    end
    n_checks++;
    if (o_mode !== 3'(m_omode)) begin
      n_errors++;
      $display("FAIL o_mode t=%0t got %0d want %0d", $time, o_mode, m_omode);
    end
    if (pipe1.act) begin
      for (int i = 0; i < n_probes; i++) begin
        if (probes[i].tag == pipe1.tag && probes[i].h == pipe1.h && probes[i].v == pipe1.v) begin
          probes[i].hit = 1'b1;
          n_checks++;
          if ({o_sync_h, o_sync_v, o_r, o_g, o_b} !== {2'b11, probes[i].rgb}) begin
            n_errors++;
            $display("FAIL probe tag %0d (%0d,%0d) got sh=%0b sv=%0b rgb=%06h want 1 1 %06h",
                     probes[i].tag, probes[i].h, probes[i].v, o_sync_h, o_sync_v,
                     {o_r, o_g, o_b}, probes[i].rgb);
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge i_pclk);
    model_step();
  end

  initial forever begin
    @(negedge i_pclk);
    if (chk_en) compare_step();
  end

  task automatic add_probe(input int tag, input int h, input int v, input logic [23:0] rgb);
    probes[n_probes] = '{tag: tag, h: h, v: v, rgb: rgb, hit: 1'b0};
    n_probes++;
  endtask

  task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic drive(input bit sh, input bit sv, input logic [23:0] rgb);
    if (mode_flip && $urandom_range(0, 31) == 0) i_mode = 3'($urandom_range(0, 7));
    i_sync_h = sh;
    i_sync_v = sv;
    {i_r, i_g, i_b} = rgb;
    @(negedge i_pclk);
  endtask

  task automatic line(input int n_act, input int n_blank);
    for (int i = 0; i < n_act; i++)   drive(1'b1, 1'b1, 24'($urandom));
    for (int i = 0; i < n_blank; i++) drive(1'b0, 1'b1, 24'($urandom));
  endtask

  task automatic vblank(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 24'($urandom));
  endtask

  initial begin
    i_rst = 1'b1; i_mode = 3'd0;
    i_sync_h = 1'b0; i_sync_v = 1'b0; i_r = 8'h0; i_g = 8'h0; i_b = 8'h0;

    // Reset with live syncs on the inputs
    drive(1'b1, 1'b1, 24'($urandom));
    chk_en = 1'b1;
    drive(1'b1, 1'b1, 24'($urandom));
    drive(1'b1, 1'b1, 24'($urandom));
    check_lit("reset_out", 32'({o_sync_h, o_sync_v, o_r, o_g, o_b}), 32'h0);
    check_lit("reset_mode", 32'(o_mode), 32'h0);
    i_rst = 1'b0;
    vblank(4);

    // Passthrough
    cur_tag = 1; i_mode = 3'd0;
    add_probe(1, 0, 0, 24'h123456);
    drive(1'b1, 1'b1, 24'h123456);
    line(39, 8);
    repeat (3) line(40, 8);
    i_mode = 3'd1;
    vblank(4);

    // Colour bars, mode change in the same cycle as the frame start
    i_mode = 3'd2; cur_tag = 2;
    add_probe(2, 0, 0, 24'hFFFFFF);
    add_probe(2, 240, 0, BORDER ? 24'hFFFFFF : 24'hFFFF00);
    add_probe(2, 1919, 0, BORDER ? 24'hFFFFFF : 24'h000000);
    line(2100, 10);
    line(50, 10);
    vblank(4);

    // RGB thirds, including lines past V_ACTIVE and vcount saturation
    i_mode = 3'd4; cur_tag = 3;
    add_probe(3, 300, 0, BORDER ? 24'hFFFFFF : 24'h2C0000);
    add_probe(3, 300, 360, 24'h002C00);
    add_probe(3, 300, 720, 24'h00002C);
    add_probe(3, 50, 2047, 24'h000032);
    line(310, 6);
    repeat (359) line(1, 1);
    line(310, 6);
    repeat (359) line(1, 1);
    line(310, 6);
    repeat (1400) line(1, 1);
    line(60, 4);
    vblank(4);

    // Flat, switched to checker mid-frame
    i_mode = 3'd1; cur_tag = 4;
    add_probe(4, 50, 1, 24'h777777);
    add_probe(4, 70, 2, 24'h777777);
    line(100, 6);
    i_mode = 3'd5;
    line(100, 6);
    line(100, 6);
    vblank(4);
    cur_tag = 5;
    add_probe(5, 64, 0, 24'hFFFFFF);
    add_probe(5, 64, 64, 24'h000000);
    add_probe(5, 10, 64, 24'hFFFFFF);
    add_probe(5, 10, 0, BORDER ? 24'hFFFFFF : 24'h000000);
    line(100, 6);
    repeat (63) line(1, 1);
    line(100, 6);
    line(100, 6);
    vblank(4);

    // Flat frame covering the border positions
    i_mode = 3'd1; cur_tag = 6;
    add_probe(6, 10, 0, BORDER ? 24'hFFFFFF : 24'h777777);
    add_probe(6, 1919, 5, BORDER ? 24'hFFFFFF : 24'h777777);
    add_probe(6, 5, 5, 24'h777777);
    line(20, 4);
    repeat (4) line(1, 1);
    line(1920, 4);
    vblank(4);

    // Reset pulse mid-line in ramp mode
    i_mode = 3'd3; cur_tag = 7;
    line(50, 6);
    repeat (20) drive(1'b1, 1'b1, 24'($urandom));
    cur_tag = 8;
    i_rst = 1'b1;
    drive(1'b1, 1'b1, 24'($urandom));
    check_lit("rst_mid_out", 32'({o_r, o_g, o_b}), 32'h0);
    check_lit("rst_mid_mode", 32'(o_mode), 32'h0);
    i_rst = 1'b0;
    drive(1'b1, 1'b1, 24'($urandom));
    check_lit("rst_relatch_mode", 32'(o_mode), 32'h3);
    add_probe(8, 5, 0, BORDER ? 24'hFFFFFF : 24'h050505);
    add_probe(8, 25, 1, 24'h191919);
    line(20, 6);
    line(30, 6);
    vblank(4);

    // Randomized frames with mid-frame mode churn and occasional missing vblank
    mode_flip = 1'b1; cur_tag = 9;
    for (int f = 0; f < 12; f++) begin
      i_mode = 3'($urandom_range(0, 7));
      for (int l = 0; l < int'($urandom_range(2, 8)); l++)
        line(int'($urandom_range(1, 300)), int'($urandom_range(1, 16)));
      vblank(int'($urandom_range(0, 4)));
    end
    mode_flip = 1'b0;
    vblank(4);

    for (int i = 0; i < n_probes; i++) begin
      if (!probes[i].hit) begin
        n_checks++;
        n_errors++;
        $display("FAIL probe_unreached tag %0d (%0d,%0d) got none want %06h",
                 probes[i].tag, probes[i].h, probes[i].v, probes[i].rgb);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
